// File: rtl/matrix_mul_seq.sv
// Sequential NxN unsigned matrix multiplier (Res = A x B), one multiply-accumulate per clock.
// Operands are captured on start; Res updates only on completion, with optional saturation.
module matrix_mul_seq #(
  parameter int N        = 2,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 8,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N*N*DATA_W-1:0]     A,
  input  logic [N*N*DATA_W-1:0]     B,
  output logic                      busy,
  output logic                      done,
  output logic [N*N*ACC_W-1:0]      Res
);

  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int ACCI_W = 2*DATA_W + $clog2(N) + 1;
  localparam int EXT_W  = (ACC_W > ACCI_W) ? ACC_W : ACCI_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t                 state_r, state_n;
  logic [N*N*DATA_W-1:0]  a_r, b_r;
  logic [IDX_W-1:0]       i_r, j_r, k_r;
  logic [ACCI_W-1:0]      acc_r, sum_s;
  logic [2*DATA_W-1:0]    prod_s;
  logic [ACC_W-1:0]       res_buf_r [N][N];
  logic [N*N*ACC_W-1:0]   res_flat_s, res_r;
  logic [DATA_W-1:0]      a_el_s [N][N];
  logic [DATA_W-1:0]      b_el_s [N][N];
  logic                   busy_r, done_r, last_s, k_last_s, j_last_s;

  // Reduction of a finished element to the output width: wrap or clamp.
  function automatic logic [ACC_W-1:0] reduce_acc(input logic [ACCI_W-1:0] v);
    logic [EXT_W-1:0] ext_v;
    logic [EXT_W-1:0] max_v;
    ext_v = EXT_W'(v);
    max_v = EXT_W'({ACC_W{1'b1}});
    if ((SATURATE != 0) && (ext_v > max_v)) begin
      reduce_acc = {ACC_W{1'b1}};
    end else begin
      reduce_acc = ext_v[ACC_W-1:0];
    end
  endfunction

  // Row-major unpacking/packing, element [0][0] sits in the MSBs.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign a_el_s[gi][gj] = a_r[(N*N-1-(gi*N+gj))*DATA_W +: DATA_W];
      assign b_el_s[gi][gj] = b_r[(N*N-1-(gi*N+gj))*DATA_W +: DATA_W];
      assign res_flat_s[(N*N-1-(gi*N+gj))*ACC_W +: ACC_W] = res_buf_r[gi][gj];
    end
  end

  assign prod_s   = (2*DATA_W)'(a_el_s[i_r][k_r]) * (2*DATA_W)'(b_el_s[k_r][j_r]);
  assign sum_s    = acc_r + ACCI_W'(prod_s);
  assign k_last_s = (k_r == LAST_IDX);
  assign j_last_s = (j_r == LAST_IDX);
  assign last_s   = k_last_s && j_last_s && (i_r == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_n = RUN;
        else       state_n = IDLE;
      end
      RUN: begin
        if (last_s) state_n = FIN;
        else        state_n = RUN;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, MAC datapath, index counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      i_r    <= '0;
      j_r    <= '0;
      k_r    <= '0;
      acc_r  <= '0;
      res_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      for (int x = 0; x < N; x++) begin
        for (int y = 0; y < N; y++) begin
          res_buf_r[x][y] <= '0;
        end
      end
    end else begin
      busy_r <= (state_n != IDLE);
      done_r <= (state_r == FIN);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r   <= A;
            b_r   <= B;
            i_r   <= '0;
            j_r   <= '0;
            k_r   <= '0;
            acc_r <= '0;
          end
        end
        RUN: begin
          if (k_last_s) begin
            // Element complete: reduce once, never on partial sums.
            res_buf_r[i_r][j_r] <= reduce_acc(sum_s);
            acc_r <= '0;
            k_r   <= '0;
            if (j_last_s) begin
              j_r <= '0;
              i_r <= (i_r == LAST_IDX) ? IDX_W'(0) : i_r + IDX_W'(1);
            end else begin
              j_r <= j_r + IDX_W'(1);
            end
          end else begin
            acc_r <= sum_s;
            k_r   <= k_r + IDX_W'(1);
          end
        end
        FIN:     res_r <= res_flat_s;
        default: res_r <= res_r;
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign Res  = res_r;

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Randomised self-checking bench for matrix_mul_seq: 2x2 wrap and saturate variants plus a 3x3
// wide-result instance, all compared against a plain-arithmetic matrix product model.
module tb_matrix_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, start3;
  logic [31:0]  a, b;
  logic [71:0]  a3, b3;
  logic         busy, done, busy_s, done_s, busy3, done3;
  logic [31:0]  res, res_s;
  logic [179:0] res3;
  int total = 0;
  int bad   = 0;

  matrix_mul_seq #(.N(2), .DATA_W(8), .ACC_W(8), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .busy(busy), .done(done), .Res(res));
  matrix_mul_seq #(.N(2), .DATA_W(8), .ACC_W(8), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .busy(busy_s), .done(done_s), .Res(res_s));
  matrix_mul_seq #(.N(3), .DATA_W(8), .ACC_W(20), .SATURATE(0)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .A(a3), .B(b3), .busy(busy3), .done(done3), .Res(res3));

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: textbook sum of products per element, then wrap or clamp to aw bits.
  function automatic logic [255:0] ref_mul(input logic [255:0] a_in, input logic [255:0] b_in,
                                           input int n, input int aw, input bit sat);
    logic [255:0] r, ta, tb;
    longint s, mx;
    r  = '0;
    mx = (longint'(1) << aw) - 1;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) begin
          ta = a_in >> ((n*n-1-(i*n+k))*8);
          tb = b_in >> ((n*n-1-(k*n+j))*8);
          s += longint'(ta[7:0]) * longint'(tb[7:0]);
        end
        if (sat && s > mx) s = mx;
        else s = s & mx;
        r |= 256'(s) << ((n*n-1-(i*n+j))*aw);
      end
    end
    return r;
  endfunction

  // One 2x2 job; optionally fires extra starts with new operands while busy.
  task automatic run2(input logic [31:0] aa, input logic [31:0] bb, input bit inject);
    int  lat;
    bit  busy_drop;
    busy_drop = 1'b0;
    lat = 0;
    @(negedge clk);
    a = aa; b = bb; start = 1'b1;
    @(posedge clk);
    #1 chk("busy_after_start", 256'(busy), 256'(1));
    @(negedge clk);
    for (int c = 0; c < 60; c++) begin
      if (inject && (c == 1 || c == 3)) begin
        start = 1'b1; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1 lat++;
      if (done) break;
      if (!busy) busy_drop = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    chk("latency2", 256'(lat), 256'(9));
    chk("res_wrap", 256'(res), ref_mul(256'(aa), 256'(bb), 2, 8, 1'b0));
    chk("res_sat", 256'(res_s), ref_mul(256'(aa), 256'(bb), 2, 8, 1'b1));
    chk("busy_falls_with_done", 256'(busy), 256'(0));
    if (inject) chk("busy_held", 256'(busy_drop), 256'(0));
    @(posedge clk);
    #1 chk("done_one_cycle", 256'(done), 256'(0));
    chk("res_held", 256'(res), ref_mul(256'(aa), 256'(bb), 2, 8, 1'b0));
  endtask

  task automatic run3(input logic [71:0] aa, input logic [71:0] bb);
    int lat;
    lat = 0;
    @(negedge clk);
    a3 = aa; b3 = bb; start3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start3 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1 lat++;
      if (done3) break;
    end
    chk("latency3", 256'(lat), 256'(28));
    chk("res3", 256'(res3), ref_mul(256'(aa), 256'(bb), 3, 20, 1'b0));
  endtask

  initial begin
    logic [31:0] sa [2];
    logic [31:0] sb [2];
    logic [71:0] id3, seq3;
    int  cyc, last, ndone;
    bit  saw_done;

    rst = 1'b1; start = 1'b0; start3 = 1'b0;
    a = '0; b = '0; a3 = '0; b3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_res", 256'(res), 256'(0));
    chk("rst_res3", 256'(res3), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    run2(32'h01020304, 32'h05060708, 1'b0);
    chk("case1_literal", 256'(res), 256'(32'h13162B32));
    run2(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("all_ones_wrap", 256'(res), 256'(32'h02020202));
    chk("all_ones_sat", 256'(res_s), 256'(32'hFFFFFFFF));
    run2(32'h01020304, 32'h05060708, 1'b1);
    chk("ignored_starts", 256'(res), 256'(32'h13162B32));

    // Reset in the middle of a run: nothing completes and Res is cleared.
    @(negedge clk);
    a = $urandom; b = $urandom; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_res", 256'(res), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1 if (done) saw_done = 1'b1;
    end
    chk("midrst_no_done", 256'(saw_done), 256'(0));
    chk("midrst_res_stays", 256'(res), 256'(0));
    run2(32'h01020304, 32'h05060708, 1'b0);

    for (int r = 0; r < 6; r++) run2($urandom, $urandom, 1'b0);

    // start held high with alternating operand sets.
    sa[0] = $urandom; sb[0] = $urandom;
    sa[1] = $urandom; sb[1] = $urandom;
    @(negedge clk);
    a = sa[0]; b = sb[0]; start = 1'b1;
    @(posedge clk);
    cyc = 0; last = 0; ndone = 0;
    for (int c = 0; c < 100 && ndone < 4; c++) begin
      @(posedge clk);
      #1 cyc++;
      if (done) begin
        chk("b2b_res", 256'(res), ref_mul(256'(sa[ndone % 2]), 256'(sb[ndone % 2]), 2, 8, 1'b0));
        chk("b2b_period", 256'(cyc - last), (ndone == 0) ? 256'(9) : 256'(10));
        last = cyc;
        ndone++;
        if (ndone == 4) begin
          start = 1'b0;
        end else begin
          a = sa[ndone % 2]; b = sb[ndone % 2];
        end
      end
    end
    start = 1'b0;
    chk("b2b_count", 256'(ndone), 256'(4));
    repeat (2) @(posedge clk);

    id3 = '0; seq3 = '0;
    for (int e = 0; e < 9; e++) begin
      if (e % 4 == 0) id3[(8-e)*8 +: 8] = 8'd1;
      seq3[(8-e)*8 +: 8] = 8'(e + 1);
    end
    run3(id3, seq3);
    chk("identity3", 256'(res3), 256'(180'h00001_00002_00003_00004_00005_00006_00007_00008_00009));
    for (int r = 0; r < 2; r++) run3({$urandom, $urandom, 8'($urandom)}, {$urandom, $urandom, 8'($urandom)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
